// File: rtl/sync_detect.sv
// sync_detect: frame sync hunter with payload delivery and flywheel header checking.
module sync_detect #(
  parameter int WIDTH = 2,
  parameter logic [WIDTH-1:0] SYNC_SYM = 2'b11,
  parameter int SYNC_LEN = 3,
  parameter int FRAME_LEN = 8,
  parameter int MAX_MISS = 2,
  localparam int IW = $clog2(FRAME_LEN),
  localparam int MW = $clog2(MAX_MISS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  output logic             locked,
  output logic             frame_start,
  output logic             data_valid,
  output logic [WIDTH-1:0] data_out,
  output logic [IW-1:0]    sym_idx,
  output logic [MW-1:0]    miss_cnt
);
  localparam int RW = SYNC_LEN > 1 ? $clog2(SYNC_LEN) : 1;
  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;
  state_t state_q;
  logic [RW-1:0] run_q;
  logic [IW-1:0] pos_q, idx_q;
  logic [MW-1:0] miss_q;
  logic [WIDTH-1:0] dout_q;
  logic bad_q, locked_q, fs_q, dv_q;
  logic match, bad_d, run_last;
  logic [MW-1:0] miss_d;
  always_comb begin
    match = in == SYNC_SYM;
    bad_d = bad_q | ~match;
    run_last = run_q == RW'(SYNC_LEN - 1);
    miss_d = miss_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
      run_q <= '0;
      pos_q <= '0;
      idx_q <= '0;
      miss_q <= '0;
      dout_q <= '0;
      bad_q <= 1'b0;
      locked_q <= 1'b0;
      fs_q <= 1'b0;
      dv_q <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      fs_q <= 1'b0;
      if (en) begin
        case (state_q)
          HUNT: begin
            run_q <= match && !run_last ? run_q + 1'b1 : '0;
            if (match && run_last) begin
              state_q <= PAYLOAD;
              locked_q <= 1'b1;
            end
          end
          PAYLOAD: begin
            dv_q <= 1'b1;
            fs_q <= pos_q == '0;
            dout_q <= in;
            idx_q <= pos_q;
            pos_q <= pos_q == IW'(FRAME_LEN - 1) ? '0 : pos_q + 1'b1;
            if (pos_q == IW'(FRAME_LEN - 1)) begin
              state_q <= CHECK;
              run_q <= '0;
              bad_q <= 1'b0;
            end
          end
          CHECK: begin
            run_q <= run_last ? '0 : run_q + 1'b1;
            bad_q <= run_last ? 1'b0 : bad_d;
            // header verdict lands on its last symbol; a miss reaching MAX_MISS drops lock
            if (run_last) begin
              state_q <= bad_d && miss_d == MW'(MAX_MISS) ? HUNT : PAYLOAD;
              locked_q <= !(bad_d && miss_d == MW'(MAX_MISS));
              miss_q <= bad_d && miss_d != MW'(MAX_MISS) ? miss_d : '0;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end
  assign locked = locked_q;
  assign frame_start = fs_q;
  assign data_valid = dv_q;
  assign data_out = dout_q;
  assign sym_idx = idx_q;
  assign miss_cnt = miss_q;
endmodule

// File: tb/tb_sync_detect.sv
// tb_sync_detect: directed-vector checks of sync_detect with default parameters.
module tb_sync_detect;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] in;
  logic en;
  logic locked, frame_start, data_valid;
  logic [1:0] data_out;
  logic [2:0] sym_idx;
  logic [1:0] miss_cnt;
  int errors = 0;
  int checks = 0;
  sync_detect dut (
    .clk(clk), .rst_n(rst_n), .in(in), .en(en),
    .locked(locked), .frame_start(frame_start), .data_valid(data_valid),
    .data_out(data_out), .sym_idx(sym_idx), .miss_cnt(miss_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic feed(input logic [1:0] s);
    in = s;
    en = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    en = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic reset_edge();
    rst_n = 1'b0;
    in = 2'b11;
    en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_dv"}, data_valid, 0);
    chk({tag, "_dout"}, data_out, 0);
    chk({tag, "_idx"}, sym_idx, 0);
    chk({tag, "_miss"}, miss_cnt, 0);
  endtask
  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    in = 2'b00;
    @(posedge clk);
    #1;
    reset_edge();
    chk_zero("reset");
    feed(2'b11);
    feed(2'b11);
    chk("lock_early", locked, 0);
    feed(2'b11);
    chk("lock_third", locked, 1);
    chk("lock_dv", data_valid, 0);
    feed(2'b01);
    chk("p0_dv", data_valid, 1);
    chk("p0_dout", data_out, 1);
    chk("p0_fs", frame_start, 1);
    chk("p0_idx", sym_idx, 0);
    feed(2'b10);
    chk("p1_dout", data_out, 2);
    chk("p1_idx", sym_idx, 1);
    chk("p1_fs", frame_start, 0);
    for (int i = 2; i < 8; i++) feed(2'b00);
    chk("p7_idx", sym_idx, 7);
    for (int i = 0; i < 3; i++) begin
      feed(2'b11);
      chk("good_hdr_dv", data_valid, 0);
      chk("good_hdr_locked", locked, 1);
    end
    chk("good_hdr_miss", miss_cnt, 0);
    feed(2'b00);
    chk("f2_fs", frame_start, 1);
    chk("f2_dout", data_out, 0);
    chk("f2_idx", sym_idx, 0);
    for (int i = 1; i < 8; i++) feed(2'b01);
    feed(2'b11);
    feed(2'b10);
    feed(2'b11);
    chk("bad1_miss", miss_cnt, 1);
    chk("bad1_locked", locked, 1);
    feed(2'b10);
    chk("fly_fs", frame_start, 1);
    chk("fly_dv", data_valid, 1);
    chk("fly_dout", data_out, 2);
    for (int i = 1; i < 8; i++) feed(2'b01);
    chk("fly_idx7", sym_idx, 7);
    feed(2'b11);
    feed(2'b10);
    feed(2'b11);
    chk("bad2_locked", locked, 0);
    chk("bad2_miss", miss_cnt, 0);
    chk("bad2_dv", data_valid, 0);
    feed(2'b11);
    feed(2'b11);
    chk("relock_early", locked, 0);
    feed(2'b11);
    chk("relock", locked, 1);
    for (int i = 0; i < 5; i++) feed(2'b01);
    chk("pre_hold_idx", sym_idx, 4);
    for (int i = 0; i < 2; i++) begin
      idle();
      chk("hold_idx", sym_idx, 4);
      chk("hold_dv", data_valid, 0);
      chk("hold_locked", locked, 1);
    end
    feed(2'b10);
    chk("resume_idx", sym_idx, 5);
    chk("resume_dv", data_valid, 1);
    feed(2'b10);
    chk("resume_idx6", sym_idx, 6);
    reset_edge();
    chk_zero("midreset");
    feed(2'b11);
    feed(2'b11);
    chk("post_rst_early", locked, 0);
    feed(2'b11);
    chk("post_rst_lock", locked, 1);
    reset_edge();
    feed(2'b11);
    feed(2'b11);
    feed(2'b10);
    feed(2'b11);
    feed(2'b11);
    chk("broken_run", locked, 0);
    feed(2'b11);
    chk("sixth_lock", locked, 1);
    feed(2'b11);
    chk("sync_as_p0_dv", data_valid, 1);
    chk("sync_as_p0_fs", frame_start, 1);
    chk("sync_as_p0_dout", data_out, 3);
    chk("sync_as_p0_idx", sym_idx, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
